// File: rtl/y86_pkg.sv
// y86_pkg: shared Y86-64 instruction codes and register IDs
package y86_pkg;
  localparam logic [3:0] IHALT = 4'h0, INOP = 4'h1, ICMOVXX = 4'h2, IIRMOVQ = 4'h3;
  localparam logic [3:0] IRMMOVQ = 4'h4, IMRMOVQ = 4'h5, IOPQ = 4'h6, IJXX = 4'h7;
  localparam logic [3:0] ICALL = 4'h8, IRET = 4'h9, IPUSHQ = 4'hA, IPOPQ = 4'hB;
  localparam logic [3:0] RRSP = 4'h4, RNONE = 4'hF;
endpackage

// File: rtl/y86_reg_sel.sv
// y86_reg_sel: maps icode/rA/rB/cnd to source and destination register IDs
module y86_reg_sel
  import y86_pkg::*;
(
  input  logic [3:0] icode,
  input  logic [3:0] rA,
  input  logic [3:0] rB,
  input  logic       cnd,
  output logic [3:0] srcA,
  output logic [3:0] srcB,
  output logic [3:0] dstE,
  output logic [3:0] dstM
);
  always_comb begin
    srcA = (icode inside {ICMOVXX, IRMMOVQ, IOPQ, IPUSHQ}) ? rA :
           (icode inside {IRET, IPOPQ}) ? RRSP : RNONE;
    srcB = (icode inside {IRMMOVQ, IMRMOVQ, IOPQ}) ? rB :
           (icode inside {ICALL, IRET, IPUSHQ, IPOPQ}) ? RRSP : RNONE;
    dstE = (icode inside {IIRMOVQ, IOPQ}) ? rB :
           (icode == ICMOVXX) ? (cnd ? rB : RNONE) :
           (icode inside {ICALL, IRET, IPUSHQ, IPOPQ}) ? RRSP : RNONE;
    dstM = (icode inside {IMRMOVQ, IPOPQ}) ? rA : RNONE;
  end
endmodule

// File: rtl/decode_regfile.sv
// decode_regfile: Y86-64 SEQ register file with decode read ports and writeback commit
module decode_regfile
  import y86_pkg::*;
#(
  parameter logic [63:0] RSP_INIT = 64'd0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [3:0]  icode,
  input  logic [3:0]  rA,
  input  logic [3:0]  rB,
  input  logic        cnd,
  input  logic [63:0] ValE,
  input  logic [63:0] ValM,
  input  logic        wb_en,
  output logic [63:0] ValA,
  output logic [63:0] ValB,
  output logic [3:0]  srcA,
  output logic [3:0]  srcB,
  output logic [3:0]  dstE,
  output logic [3:0]  dstM,
  output logic [63:0] reg0,
  output logic [63:0] reg1,
  output logic [63:0] reg2,
  output logic [63:0] reg3,
  output logic [63:0] reg4,
  output logic [63:0] reg5,
  output logic [63:0] reg6,
  output logic [63:0] reg7,
  output logic [63:0] reg8,
  output logic [63:0] reg9,
  output logic [63:0] reg10,
  output logic [63:0] reg11,
  output logic [63:0] reg12,
  output logic [63:0] reg13,
  output logic [63:0] reg14
);
  logic [63:0] rf [15];
  y86_reg_sel u_sel (
    .icode(icode),
    .rA(rA),
    .rB(rB),
    .cnd(cnd),
    .srcA(srcA),
    .srcB(srcB),
    .dstE(dstE),
    .dstM(dstM)
  );
  assign ValA = (srcA == RNONE) ? 64'd0 : rf[srcA];
  assign ValB = (srcB == RNONE) ? 64'd0 : rf[srcB];
  // M write follows E so it wins when both target the same register (popq %rsp)
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 15; i++) rf[i] <= (i == 4) ? RSP_INIT : 64'd0;
    end else if (wb_en) begin
      if (dstE != RNONE) rf[dstE] <= ValE;
      if (dstM != RNONE) rf[dstM] <= ValM;
    end
  end
  assign reg0  = rf[0];
  assign reg1  = rf[1];
  assign reg2  = rf[2];
  assign reg3  = rf[3];
  assign reg4  = rf[4];
  assign reg5  = rf[5];
  assign reg6  = rf[6];
  assign reg7  = rf[7];
  assign reg8  = rf[8];
  assign reg9  = rf[9];
  assign reg10 = rf[10];
  assign reg11 = rf[11];
  assign reg12 = rf[12];
  assign reg13 = rf[13];
  assign reg14 = rf[14];
endmodule

// File: tb/tb_decode_regfile.sv
// tb_decode_regfile: directed vectors with hand-computed expectations for decode_regfile
module tb_decode_regfile;
  localparam logic [63:0] RSP0 = 64'd256;
  logic        clk = 0;
  logic        reset, cnd, wb_en;
  logic [3:0]  icode, rA, rB, srcA, srcB, dstE, dstM;
  logic [63:0] ValE, ValM, ValA, ValB;
  logic [63:0] r [15];
  int npass = 0, ntot = 0;
  decode_regfile #(.RSP_INIT(RSP0)) dut (
    .clk(clk), .reset(reset), .icode(icode), .rA(rA), .rB(rB), .cnd(cnd),
    .ValE(ValE), .ValM(ValM), .wb_en(wb_en), .ValA(ValA), .ValB(ValB),
    .srcA(srcA), .srcB(srcB), .dstE(dstE), .dstM(dstM),
    .reg0(r[0]), .reg1(r[1]), .reg2(r[2]), .reg3(r[3]), .reg4(r[4]),
    .reg5(r[5]), .reg6(r[6]), .reg7(r[7]), .reg8(r[8]), .reg9(r[9]),
    .reg10(r[10]), .reg11(r[11]), .reg12(r[12]), .reg13(r[13]), .reg14(r[14])
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    ntot++;
    if (got === exp) npass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask
  task automatic drive(input logic [3:0] ic, input logic [3:0] a, input logic [3:0] b,
                       input logic c, input logic [63:0] e, input logic [63:0] m);
    icode = ic; rA = a; rB = b; cnd = c; ValE = e; ValM = m;
    #1;
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic chk_reset_state(input string tag);
    for (int i = 0; i < 15; i++)
      chk($sformatf("%s_r%0d", tag, i), r[i], (i == 4) ? RSP0 : 64'd0);
  endtask
  initial begin
    reset = 1; wb_en = 1;
    drive(4'h1, 4'hF, 4'hF, 0, 0, 0);
    step();
    reset = 0;
    chk_reset_state("reset");
    drive(4'h3, 4'hF, 4'h3, 0, 64'd20, 0);
    chk("irmov_dstE", 64'(dstE), 64'h3);
    chk("irmov_dstM", 64'(dstM), 64'hF);
    step();
    chk("irmov_rbx", r[3], 64'd20);
    chk("irmov_rsp", r[4], RSP0);
    chk("irmov_rax", r[0], 64'd0);
    drive(4'h2, 4'h3, 4'h0, 1, 64'd12, 0);
    chk("cmov1_ValA", ValA, 64'd20);
    chk("cmov1_dstE", 64'(dstE), 64'h0);
    step();
    chk("cmov1_rax", r[0], 64'd12);
    drive(4'h2, 4'h3, 4'h0, 0, 64'd99, 0);
    chk("cmov0_dstE", 64'(dstE), 64'hF);
    step();
    chk("cmov0_rax", r[0], 64'd12);
    drive(4'h5, 4'h2, 4'h3, 0, 64'd0, 64'd15);
    chk("mrmov_ValB", ValB, 64'd20);
    chk("mrmov_dstM", 64'(dstM), 64'h2);
    chk("mrmov_dstE", 64'(dstE), 64'hF);
    step();
    chk("mrmov_rdx", r[2], 64'd15);
    drive(4'h6, 4'h2, 4'h1, 0, 64'd78, 0);
    chk("opq_ValA", ValA, 64'd15);
    chk("opq_srcB", 64'(srcB), 64'h1);
    step();
    chk("opq_rcx", r[1], 64'd78);
    drive(4'hB, 4'h5, 4'hF, 0, 64'd99, 64'd100);
    chk("pop_srcA", 64'(srcA), 64'h4);
    chk("pop_ValA", ValA, RSP0);
    chk("pop_ValB", ValB, RSP0);
    step();
    chk("pop_rsp", r[4], 64'd99);
    chk("pop_rbp", r[5], 64'd100);
    drive(4'hB, 4'h4, 4'hF, 0, 64'd50, 64'd7);
    step();
    chk("poprsp_rsp", r[4], 64'd7);
    wb_en = 0;
    drive(4'h8, 4'hF, 4'hF, 0, 64'd90, 0);
    chk("call_srcB", 64'(srcB), 64'h4);
    chk("call_ValB", ValB, 64'd7);
    step();
    chk("call_stall_rsp", r[4], 64'd7);
    wb_en = 1;
    #1;
    step();
    chk("call_rsp", r[4], 64'd90);
    drive(4'h9, 4'hF, 4'hF, 0, 64'd84, 0);
    chk("ret_ValA", ValA, 64'd90);
    chk("ret_ValB", ValB, 64'd90);
    step();
    chk("ret_rsp", r[4], 64'd84);
    reset = 1;
    drive(4'h3, 4'hF, 4'h3, 0, 64'd5, 0);
    step();
    reset = 0;
    chk_reset_state("rst2");
    drive(4'hC, 4'h0, 4'h0, 1, 64'd33, 64'd44);
    chk("ic_c_srcA", 64'(srcA), 64'hF);
    chk("ic_c_srcB", 64'(srcB), 64'hF);
    chk("ic_c_dstE", 64'(dstE), 64'hF);
    chk("ic_c_dstM", 64'(dstM), 64'hF);
    chk("ic_c_ValA", ValA, 64'd0);
    chk("ic_c_ValB", ValB, 64'd0);
    step();
    chk_reset_state("ic_c");
    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end
endmodule
